// File: rtl/switchs.sv
// switchs: memory-mapped input block for 16 slide switches and 5 push buttons.
// Every raw pad bit passes through a 2-flop synchronizer and its own debouncer.
// The CPU reads the debounced switch levels, the debounced button levels, or the
// sticky button-press flags. The press flags clear when they are read.
//
// Ports:
//   switch_clk   block clock, rising edge
//   switchrst    synchronous active-high reset
//   switchcs     block select from memorio decode
//   switchread   read enable
//   switchaddr   00 switches, 01 button levels, 10 press flags, 11 reserved
//   switch_i     raw slide switches (asynchronous)
//   button_i     raw push buttons, active-high (asynchronous)
//   switchrdata  combinational read data
module switchs #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic        switch_clk,
  input  logic        switchrst,
  input  logic        switchcs,
  input  logic        switchread,
  input  logic [1:0]  switchaddr,
  input  logic [15:0] switch_i,
  input  logic [4:0]  button_i,
  output logic [15:0] switchrdata
);

  localparam int unsigned NBITS = 21;
  localparam int unsigned CW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NBITS-1:0] sync1;
  logic [NBITS-1:0] sync2;
  logic [NBITS-1:0] stable;
  logic [NBITS-1:0] stable_nxt;
  logic [CW-1:0]    cnt     [NBITS];
  logic [CW-1:0]    cnt_nxt [NBITS];
  logic [4:0]       press;
  logic [4:0]       press_set;
  logic [4:0]       press_clr;
  logic             rd_en;

  // Next-state for the debouncers is computed combinationally so that the
  // press flags can see a stable rise on the same edge it happens.
  always_comb begin
    stable_nxt = stable;
    for (int unsigned i = 0; i < NBITS; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_nxt[i] = sync2[i];
          cnt_nxt[i]    = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  assign rd_en     = switchcs && switchread;
  assign press_set = stable_nxt[20:16] & ~stable[20:16];
  assign press_clr = (rd_en && (switchaddr == 2'b10)) ? '1 : '0;

  always_ff @(posedge switch_clk) begin
    if (switchrst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      press  <= '0;
      for (int unsigned i = 0; i < NBITS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1  <= {button_i, switch_i};
      sync2  <= sync1;
      stable <= stable_nxt;
      // Set has priority over the read-clear on a per-bit basis.
      press  <= (press & ~press_clr) | press_set;
      for (int unsigned i = 0; i < NBITS; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  always_comb begin
    switchrdata = '0;
    if (rd_en) begin
      case (switchaddr)
        2'b00:   switchrdata = stable[15:0];
        2'b01:   switchrdata = {11'b0, stable[20:16]};
        2'b10:   switchrdata = {11'b0, press};
        default: switchrdata = '0;
      endcase
    end
  end

endmodule
